// File: rtl/armleocpu_jtag_tap_mc.sv
// armleocpu_jtag_tap_mc: multi-chain JTAG TAP, fully synchronous to clk.
// TCK/TMS/TDI are oversampled through synchroniser flops; the 16-state
// controller advances on detected TCK edges. The TAP holds IR, IDCODE and
// BYPASS, plus CHAINS parallel-capture/parallel-update user DRs.
// Optional feature: define ARMLEOCPU_JTAG_TRST_PIN_EN to add the trst_ni pad.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   trst_ni                (ARMLEOCPU_JTAG_TRST_PIN_EN only) async TRST pad
//   tck_i, tms_i, td_i     JTAG input pads
//   td_o, td_oe_o          TDO pad and its output enable
//   ir_o, tlr_o            current instruction, TestLogicReset flag
//   chain_capture_o        per-chain CaptureDr strobe
//   chain_update_o         per-chain UpdateDr strobe
//   chain_cap_data_i       per-chain capture values, chain i at [i*DR_WIDTH +: DR_WIDTH]
//   chain_upd_data_o       per-chain update registers, same packing
module armleocpu_jtag_tap_mc #(
  parameter int unsigned IR_LENGTH    = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'h80000001,
  parameter int unsigned CHAINS       = 2,
  parameter int unsigned DR_WIDTH     = 32,
  parameter int unsigned USER_BASE    = 'h10,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef ARMLEOCPU_JTAG_TRST_PIN_EN
  input  logic                         trst_ni,
`endif
  input  logic                         tck_i,
  input  logic                         tms_i,
  input  logic                         td_i,
  output logic                         td_o,
  output logic                         td_oe_o,
  output logic [IR_LENGTH-1:0]         ir_o,
  output logic                         tlr_o,
  output logic [CHAINS-1:0]            chain_capture_o,
  output logic [CHAINS-1:0]            chain_update_o,
  input  logic [CHAINS*DR_WIDTH-1:0]   chain_cap_data_i,
  output logic [CHAINS*DR_WIDTH-1:0]   chain_upd_data_o
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR,
    S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
  } state_t;

  state_t                    r_state, w_state_next;
  logic [SYNC_STAGES-1:0]    r_tck_sync, r_tms_sync, r_tdi_sync;
  logic [SYNC_STAGES:0]      r_fill;
  logic                      r_tck_prev;
  logic                      w_tck_pos, w_tck_neg, w_tms, w_tdi, w_trst;
  logic [IR_LENGTH-1:0]      r_ir, r_ir_shift;
  logic [31:0]               r_idcode_sr;
  logic                      r_bypass;
  logic [DR_WIDTH-1:0]       r_chain_sr [CHAINS];
  logic [CHAINS*DR_WIDTH-1:0] r_upd_data;
  logic [CHAINS-1:0]         r_cap, r_upd, w_sel_chain;
  logic                      w_sel_idcode, w_dr_lsb;
  logic                      r_td, r_td_oe, r_tlr;

  // Pad synchronisers; r_fill suppresses edges until the pipeline holds real samples,
  // so a TCK already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_tck_prev <= 1'b0;
      r_fill     <= '0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck_i};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms_i};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], td_i};
      r_tck_prev <= r_tck_sync[SYNC_STAGES-1];
      r_fill     <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_tck_pos = r_fill[SYNC_STAGES] &  r_tck_sync[SYNC_STAGES-1] & ~r_tck_prev;
  assign w_tck_neg = r_fill[SYNC_STAGES] & ~r_tck_sync[SYNC_STAGES-1] &  r_tck_prev;
  assign w_tms     = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi     = r_tdi_sync[SYNC_STAGES-1];

`ifdef ARMLEOCPU_JTAG_TRST_PIN_EN
  logic [SYNC_STAGES-1:0] r_trst_sync;
  always_ff @(posedge clk) begin
    if (rst) r_trst_sync <= '1;
    else     r_trst_sync <= {r_trst_sync[SYNC_STAGES-2:0], trst_ni};
  end
  assign w_trst = ~r_trst_sync[SYNC_STAGES-1];
`else
  assign w_trst = 1'b0;
`endif

  // TAP state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_TLR;
    else     r_state <= w_state_next;
  end

  // IEEE 1149.1 next-state graph, advanced on TCK rising edges only
  always_comb begin
    w_state_next = r_state;
    if (w_tck_pos) begin
      case (r_state)
        S_TLR:      w_state_next = w_tms ? S_TLR      : S_RTI;
        S_RTI:      w_state_next = w_tms ? S_SEL_DR   : S_RTI;
        S_SEL_DR:   w_state_next = w_tms ? S_SEL_IR   : S_CAP_DR;
        S_CAP_DR:   w_state_next = w_tms ? S_EXIT1_DR : S_SHIFT_DR;
        S_SHIFT_DR: w_state_next = w_tms ? S_EXIT1_DR : S_SHIFT_DR;
        S_EXIT1_DR: w_state_next = w_tms ? S_UPD_DR   : S_PAUSE_DR;
        S_PAUSE_DR: w_state_next = w_tms ? S_EXIT2_DR : S_PAUSE_DR;
        S_EXIT2_DR: w_state_next = w_tms ? S_UPD_DR   : S_SHIFT_DR;
        S_UPD_DR:   w_state_next = w_tms ? S_SEL_DR   : S_RTI;
        S_SEL_IR:   w_state_next = w_tms ? S_TLR      : S_CAP_IR;
        S_CAP_IR:   w_state_next = w_tms ? S_EXIT1_IR : S_SHIFT_IR;
        S_SHIFT_IR: w_state_next = w_tms ? S_EXIT1_IR : S_SHIFT_IR;
        S_EXIT1_IR: w_state_next = w_tms ? S_UPD_IR   : S_PAUSE_IR;
        S_PAUSE_IR: w_state_next = w_tms ? S_EXIT2_IR : S_PAUSE_IR;
        S_EXIT2_IR: w_state_next = w_tms ? S_UPD_IR   : S_SHIFT_IR;
        S_UPD_IR:   w_state_next = w_tms ? S_SEL_DR   : S_RTI;
        default:    w_state_next = S_TLR;
      endcase
    end
    if (w_trst) w_state_next = S_TLR;
  end

  // Instruction decode; anything that is neither IDCODE nor a user chain is BYPASS
  always_comb begin
    w_sel_idcode = (r_ir == IR_LENGTH'(1));
    w_sel_chain  = '0;
    for (int unsigned i = 0; i < CHAINS; i++)
      w_sel_chain[i] = (r_ir == IR_LENGTH'(USER_BASE + i));
  end

  // LSB of the currently selected DR, feeding TDO
  always_comb begin
    w_dr_lsb = r_bypass;
    if (w_sel_idcode) w_dr_lsb = r_idcode_sr[0];
    for (int unsigned i = 0; i < CHAINS; i++)
      if (w_sel_chain[i]) w_dr_lsb = r_chain_sr[i][0];
  end

  // IR, data registers, strobes and TDO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir        <= IR_LENGTH'(1);
      r_ir_shift  <= '0;
      r_idcode_sr <= '0;
      r_bypass    <= 1'b0;
      for (int unsigned i = 0; i < CHAINS; i++) r_chain_sr[i] <= '0;
      r_upd_data  <= '0;
      r_cap       <= '0;
      r_upd       <= '0;
      r_td        <= 1'b0;
      r_td_oe     <= 1'b0;
      r_tlr       <= 1'b1;
    end else begin
      r_cap <= '0;
      r_upd <= '0;
      r_tlr <= (w_state_next == S_TLR);

      if (r_state == S_TLR || w_trst)
        r_ir <= IR_LENGTH'(1);
      else if (w_tck_neg && r_state == S_UPD_IR)
        r_ir <= r_ir_shift;

      if (w_tck_pos && !w_trst) begin
        case (r_state)
          S_CAP_IR:   r_ir_shift <= IR_LENGTH'(1);
          S_SHIFT_IR: r_ir_shift <= {w_tdi, r_ir_shift[IR_LENGTH-1:1]};
          S_CAP_DR: begin
            if (w_sel_idcode) r_idcode_sr <= IDCODE_VALUE;
            else if (w_sel_chain == '0) r_bypass <= 1'b0;
            for (int unsigned i = 0; i < CHAINS; i++)
              if (w_sel_chain[i]) begin
                r_chain_sr[i] <= chain_cap_data_i[i*DR_WIDTH +: DR_WIDTH];
                r_cap[i]      <= 1'b1;
              end
          end
          S_SHIFT_DR: begin
            if (w_sel_idcode) r_idcode_sr <= {w_tdi, r_idcode_sr[31:1]};
            else if (w_sel_chain == '0) r_bypass <= w_tdi;
            // Width-1 chains degenerate to loading TDI
            for (int unsigned i = 0; i < CHAINS; i++)
              if (w_sel_chain[i])
                r_chain_sr[i] <= DR_WIDTH'({w_tdi, r_chain_sr[i]} >> 1);
          end
          S_UPD_DR: begin
            for (int unsigned i = 0; i < CHAINS; i++)
              if (w_sel_chain[i]) begin
                r_upd_data[i*DR_WIDTH +: DR_WIDTH] <= r_chain_sr[i];
                r_upd[i]                           <= 1'b1;
              end
          end
          default: ;
        endcase
      end

      // TDO changes only on falling TCK so the host samples a stable bit on the rise
      if (w_trst) begin
        r_td    <= 1'b0;
        r_td_oe <= 1'b0;
      end else if (w_tck_neg) begin
        r_td    <= 1'b0;
        r_td_oe <= 1'b0;
        if (r_state == S_SHIFT_IR) begin
          r_td    <= r_ir_shift[0];
          r_td_oe <= 1'b1;
        end else if (r_state == S_SHIFT_DR) begin
          r_td    <= w_dr_lsb;
          r_td_oe <= 1'b1;
        end
      end
    end
  end

  assign td_o             = r_td;
  assign td_oe_o          = r_td_oe;
  assign ir_o             = r_ir;
  assign tlr_o            = r_tlr;
  assign chain_capture_o  = r_cap;
  assign chain_update_o   = r_upd;
  assign chain_upd_data_o = r_upd_data;

endmodule
